// File: rtl/game_pkg.sv
// Shared types and constants for the quadrant-guessing round sequencer.
package game_pkg;

    typedef logic [2:0] quad_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SHOW     = 3'd1,
        WAIT_SEL = 3'd2,
        COMPARE  = 3'd3,
        RESULT   = 3'd4,
        GAMEOVER = 3'd5
    } state_t;

    localparam logic [3:0] STEP_IDLE  = 4'd0;
    localparam logic [3:0] STEP_FIRST = 4'd1;
    localparam logic [3:0] STEP_LAST  = 4'd5;
    localparam logic [3:0] STEP_SEL   = 4'd6;
    localparam logic [3:0] STEP_CMP   = 4'd7;

    // Cycles spent at STEP_CMP; covers the comparator's two register stages.
    localparam int CMP_WAIT = 3;

endpackage

// File: rtl/quad_lfsr.sv
// Free-running 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) reduced to a legal quadrant.
module quad_lfsr
    import game_pkg::*;
#(
    parameter int          NUM_QUAD  = 6,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic  clk,
    input  logic  rst,
    output quad_t draw
);

    localparam logic [3:0] NQ = 4'(NUM_QUAD);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) lfsr_q <= LFSR_SEED;
        else      lfsr_q <= lfsr_d;
    end

    // For NUM_QUAD >= 4 this is a single conditional subtract; the modulo also keeps
    // small NUM_QUAD values legal.
    always_comb begin
        draw = quad_t'({1'b0, lfsr_q[2:0]} % NQ);
    end

endmodule

// File: rtl/game_round_sequencer.sv
// Round sequencer for the quadrant game: step codes, target draw, highlight, scoring.
// Define SEL_TIMEOUT_EN to force a miss after four idle intervals in WAIT_SEL.
module game_round_sequencer
    import game_pkg::*;
#(
    parameter int         STEP_TICKS = 25_000_000,
    parameter int         NUM_QUAD   = 6,
    parameter int         SCORE_W    = 4,
    parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               btn_valid,
    input  logic [2:0]         btn_quad,
    input  logic               win,
    input  logic               finish,
    output logic [3:0]         step,
    output logic [2:0]         cuadranterandom,
    output logic [2:0]         icuadrante,
    output logic               highlight_en,
    output logic [SCORE_W-1:0] score,
    output logic               game_over,
    output logic               busy
);

    localparam int            TW        = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(STEP_TICKS - 1);
    localparam logic [TW-1:0] CMP_LAST  = TW'(CMP_WAIT - 1);
    localparam logic [3:0]    NQ        = 4'(NUM_QUAD);

    state_t             state_q, state_d;
    logic [3:0]         step_q, step_d;
    logic [TW-1:0]      tick_q, tick_d;
    logic               hl_q, hl_d;
    quad_t              cuad_q, cuad_d;
    quad_t              icuad_q, icuad_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic               go_q, go_d;
    logic               busy_q, busy_d;

    quad_t lfsr_draw;
    logic  ivl_end;
    logic  sel_legal;
    logic  verdict_miss;
    logic  draw_load, sel_take, score_clr, score_inc;

`ifdef SEL_TIMEOUT_EN
    localparam int SEL_TIMEOUT_IVL = 4;
    logic [1:0] ivl_q, ivl_d;
    logic       sel_expired;
    logic       sel_timeout;
    logic [3:0] inc_raw;

    assign sel_expired = ivl_end && (ivl_q == 2'(SEL_TIMEOUT_IVL - 1));
    assign inc_raw     = {1'b0, cuad_q} + 4'd1;
`endif

    quad_lfsr #(
        .NUM_QUAD  (NUM_QUAD),
        .LFSR_SEED (LFSR_SEED)
    ) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .draw (lfsr_draw)
    );

    assign ivl_end      = (tick_q == TICK_LAST);
    assign sel_legal    = ({1'b0, btn_quad} < NQ);
    // Anything other than a hit ends the game, including a silent comparator.
    assign verdict_miss = finish | ~win;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            step_q  <= STEP_IDLE;
            tick_q  <= '0;
            hl_q    <= 1'b0;
            cuad_q  <= '0;
            icuad_q <= '0;
            score_q <= '0;
            go_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            tick_q  <= tick_d;
            hl_q    <= hl_d;
            cuad_q  <= cuad_d;
            icuad_q <= icuad_d;
            score_q <= score_d;
            go_q    <= go_d;
            busy_q  <= busy_d;
        end
    end

`ifdef SEL_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ivl_q <= '0;
        else      ivl_q <= ivl_d;
    end
`endif

    always_comb begin : next_state
        state_d   = state_q;
        step_d    = step_q;
        draw_load = 1'b0;
        sel_take  = 1'b0;
        score_clr = 1'b0;
        score_inc = 1'b0;
`ifdef SEL_TIMEOUT_EN
        sel_timeout = 1'b0;
`endif
        case (state_q)
            IDLE, GAMEOVER: begin
                if (start) begin
                    state_d   = SHOW;
                    step_d    = STEP_FIRST;
                    draw_load = 1'b1;
                    score_clr = 1'b1;
                end
            end
            SHOW: begin
                if (ivl_end) begin
                    if (step_q == STEP_LAST) begin
                        state_d = WAIT_SEL;
                        step_d  = STEP_SEL;
                    end else begin
                        step_d = step_q + 4'd1;
                    end
                end
            end
            WAIT_SEL: begin
                if (btn_valid && sel_legal) begin
                    state_d  = COMPARE;
                    step_d   = STEP_CMP;
                    sel_take = 1'b1;
                end
`ifdef SEL_TIMEOUT_EN
                else if (sel_expired) begin
                    state_d     = COMPARE;
                    step_d      = STEP_CMP;
                    sel_timeout = 1'b1;
                end
`endif
            end
            COMPARE: begin
                if (tick_q == CMP_LAST) begin
                    step_d = STEP_IDLE;
                    if (win) begin
                        state_d   = RESULT;
                        score_inc = 1'b1;
                    end else if (verdict_miss) begin
                        state_d = GAMEOVER;
                    end
                end
            end
            RESULT: begin
                if (ivl_end) begin
                    state_d   = SHOW;
                    step_d    = STEP_FIRST;
                    draw_load = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                step_d  = STEP_IDLE;
            end
        endcase
    end

    always_comb begin : outputs
        // The tick counter restarts whenever the state or step code moves.
        tick_d = (state_d != state_q || step_d != step_q || ivl_end) ? '0 : tick_q + TW'(1);
        hl_d   = (state_d == SHOW) && step_d[0];
        busy_d = !(state_d == IDLE || state_d == GAMEOVER);
        go_d   = (state_d == GAMEOVER);
        cuad_d = draw_load ? lfsr_draw : cuad_q;

        icuad_d = icuad_q;
        if (sel_take) icuad_d = btn_quad;
`ifdef SEL_TIMEOUT_EN
        if (sel_timeout) icuad_d = quad_t'((inc_raw >= NQ) ? inc_raw - NQ : inc_raw);
        if (state_d != state_q)                  ivl_d = '0;
        else if (state_q == WAIT_SEL && ivl_end) ivl_d = ivl_q + 2'd1;
        else                                     ivl_d = ivl_q;
`endif

        score_d = score_q;
        if (score_clr)                        score_d = '0;
        else if (score_inc && score_q != '1) score_d = score_q + SCORE_W'(1);
    end

    assign step            = step_q;
    assign cuadranterandom = cuad_q;
    assign icuadrante      = icuad_q;
    assign highlight_en    = hl_q;
    assign score           = score_q;
    assign game_over       = go_q;
    assign busy            = busy_q;

endmodule

// File: tb/tb_game_round_sequencer.sv
// Randomized bench for game_round_sequencer against a round-level reference model.
module tb_game_round_sequencer;

    localparam int         ST   = 4;
    localparam int         NQ   = 6;
    localparam int         SW   = 2;
    localparam logic [7:0] SEED = 8'hA5;
    localparam int         SMAX = (1 << SW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0, btn_valid = 1'b0, win = 1'b0, finish = 1'b0;
    logic [2:0]    btn_quad = 3'd0;
    logic [3:0]    step;
    logic [2:0]    cuad, icuad;
    logic          hl, go, busy;
    logic [SW-1:0] score;

    int n_tot = 0;
    int n_bad = 0;

    // Reference state: score, latched choice, current target, LFSR draw history.
    int         m_score  = 0;
    int         m_icuad  = 0;
    int         m_target = 0;
    int         m_draw   = 0;
    logic [7:0] m_lfsr;

    always #5 clk = ~clk;

    game_round_sequencer #(
        .STEP_TICKS (ST),
        .NUM_QUAD   (NQ),
        .SCORE_W    (SW),
        .LFSR_SEED  (SEED)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .btn_valid       (btn_valid),
        .btn_quad        (btn_quad),
        .win             (win),
        .finish          (finish),
        .step            (step),
        .cuadranterandom (cuad),
        .icuadrante      (icuad),
        .highlight_en    (hl),
        .score           (score),
        .game_over       (go),
        .busy            (busy)
    );

    function automatic int draw_of(input logic [7:0] l);
        int q;
        q = int'(l[2:0]);
        return (q >= NQ) ? q - NQ : q;
    endfunction

    // m_draw holds the draw the DUT would have loaded at the most recent edge.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_lfsr <= SEED;
        end else begin
            m_draw <= draw_of(m_lfsr);
            m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_step"}, 32'(step), 0);
        chk({tag, "_cuad"}, 32'(cuad), 0);
        chk({tag, "_icuad"}, 32'(icuad), 0);
        chk({tag, "_hl"}, 32'(hl), 0);
        chk({tag, "_score"}, 32'(score), 0);
        chk({tag, "_go"}, 32'(go), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
    endtask

    task automatic start_game(input bit with_btn);
        start     = 1'b1;
        btn_valid = with_btn;
        btn_quad  = 3'($urandom_range(0, 7));
        @(negedge clk);
        start     = 1'b0;
        btn_valid = 1'b0;
        m_score   = 0;
        m_target  = m_draw;
        chk("start_step", 32'(step), 1);
        chk("start_tgt", 32'(cuad), 32'(m_target));
        chk("start_score", 32'(score), 0);
        chk("start_go", 32'(go), 0);
        chk("start_busy", 32'(busy), 1);
        chk("start_icuad", 32'(icuad), 32'(m_icuad));
    endtask

    // Five highlight steps of ST cycles each; start and button noise must be ignored.
    task automatic show_phase();
        for (int i = 0; i < 5 * ST; i++) begin
            chk("show_step", 32'(step), 32'(1 + i / ST));
            chk("show_hl", 32'(hl), 32'((1 + i / ST) % 2));
            chk("show_tgt", 32'(cuad), 32'(m_target));
            start     = ($urandom_range(0, 3) == 0);
            btn_valid = $urandom_range(0, 1);
            btn_quad  = 3'($urandom_range(0, 7));
            @(negedge clk);
        end
        start     = 1'b0;
        btn_valid = 1'b0;
        chk("sel_step", 32'(step), 6);
        chk("sel_hl", 32'(hl), 0);
        chk("show_icuad", 32'(icuad), 32'(m_icuad));
    endtask

    task automatic wait_sel(input bit hit);
        int d;
        d = $urandom_range(0, 10);
        for (int i = 0; i < d; i++) begin
            btn_valid = $urandom_range(0, 1);
            btn_quad  = 3'(NQ + $urandom_range(0, 1));
            @(negedge clk);
            chk("sel_hold", 32'(step), 6);
            chk("sel_icuad", 32'(icuad), 32'(m_icuad));
        end
        btn_valid = 1'b1;
        btn_quad  = hit ? 3'(m_target) : 3'((m_target + 1 + $urandom_range(0, NQ - 2)) % NQ);
        m_icuad   = int'(btn_quad);
        @(negedge clk);
        btn_valid = 1'b0;
        chk("cmp_step", 32'(step), 7);
        chk("cmp_icuad", 32'(icuad), 32'(m_icuad));
    endtask

    // Verdict lines carry noise until the third compare cycle, where the real verdict sits.
    task automatic compare(input bit hit);
        for (int k = 1; k <= 3; k++) begin
            chk("cmp_hold", 32'(step), 7);
            chk("cmp_busy", 32'(busy), 1);
            if (k < 3) begin
                win    = $urandom_range(0, 1);
                finish = $urandom_range(0, 1);
            end else begin
                win    = hit;
                finish = $urandom_range(0, 1);
            end
            @(negedge clk);
        end
        win    = 1'b0;
        finish = 1'b0;
        if (hit) begin
            m_score = (m_score == SMAX) ? SMAX : m_score + 1;
            for (int i = 0; i < ST; i++) begin
                chk("res_step", 32'(step), 0);
                chk("res_score", 32'(score), 32'(m_score));
                chk("res_busy", 32'(busy), 1);
                chk("res_go", 32'(go), 0);
                @(negedge clk);
            end
            m_target = m_draw;
            chk("next_step", 32'(step), 1);
            chk("next_tgt", 32'(cuad), 32'(m_target));
        end else begin
            for (int i = 0; i < 3; i++) begin
                chk("go_flag", 32'(go), 1);
                chk("go_step", 32'(step), 0);
                chk("go_busy", 32'(busy), 0);
                chk("go_score", 32'(score), 32'(m_score));
                chk("go_icuad", 32'(icuad), 32'(m_icuad));
                btn_valid = $urandom_range(0, 1);
                btn_quad  = 3'($urandom_range(0, NQ - 1));
                @(negedge clk);
            end
            btn_valid = 1'b0;
        end
    endtask

    task automatic play_round(input bit hit);
        show_phase();
        wait_sel(hit);
        compare(hit);
    endtask

    initial begin
        // Reset held with random inputs.
        start     = $urandom_range(0, 1);
        btn_valid = $urandom_range(0, 1);
        btn_quad  = 3'($urandom_range(0, 7));
        win       = $urandom_range(0, 1);
        finish    = $urandom_range(0, 1);
        #17;
        chk_zero("rst");
        @(negedge clk);
        start  = 1'b0;
        win    = 1'b0;
        finish = 1'b0;
        rst    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            btn_valid = $urandom_range(0, 1);
            btn_quad  = 3'($urandom_range(0, 7));
            @(negedge clk);
            chk("idle_step", 32'(step), 0);
            chk("idle_busy", 32'(busy), 0);
            chk("idle_icuad", 32'(icuad), 0);
        end

        // Start collides with a button press; five hits saturate the score, then a miss.
        start_game(1'b1);
        for (int r = 0; r < 6; r++) play_round(r < 5);

        // Restart from GAMEOVER and play random games.
        for (int g = 0; g < 4; g++) begin
            start_game(1'b0);
            for (int r = 0; r < 8; r++) begin
                bit hit;
                hit = (r < 7) && ($urandom_range(0, 2) != 0);
                play_round(hit);
                if (!hit) break;
            end
        end

`ifdef SEL_TIMEOUT_EN
        start_game(1'b0);
        show_phase();
        for (int i = 0; i < 16; i++) begin
            chk("to_wait", 32'(step), 6);
            @(negedge clk);
        end
        m_icuad = (m_target + 1) % NQ;
        chk("to_step", 32'(step), 7);
        chk("to_icuad", 32'(icuad), 32'(m_icuad));
        compare(1'b0);
`endif

        // Asynchronous reset in the middle of the compare window.
        start_game(1'b0);
        show_phase();
        wait_sel(1'b1);
        @(negedge clk);
        chk("ar_pre", 32'(step), 7);
        #2;
        rst = 1'b0;
        #1;
        chk_zero("areset");
        @(negedge clk);
        rst     = 1'b1;
        m_icuad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("ar_idle", 32'(step), 0);
            chk("ar_busy", 32'(busy), 0);
        end
        start_game(1'b0);
        play_round(1'b0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
